antirrebote_updown: RTL and testbench

Input-conditioning stage directly upstream of the 4-bit up/down counter. Takes two raw, bouncing, asynchronous push-button levels (up, down), synchronizes and debounces each, and emits clean single-cycle `up`/`down` pulses. The counter's `up` and `down` inputs are driven from these pulses, so one press produces exactly one count step.

---
 rtl/antirrebote_updown_if.sv | 27 ++
 rtl/antirrebote_updown.sv | 158 +++++++++++++++
 tb/tb_antirrebote_updown.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/antirrebote_updown_if.sv
// rtl/antirrebote_updown_if.sv - raw button inputs and conditioned pulse/level outputs
interface antirrebote_updown_if;
    logic btn_up;
    logic btn_down;
    logic up;
    logic down;
    logic up_level;
    logic down_level;

    modport master (
        output btn_up,
        output btn_down,
        input  up,
        input  down,
        input  up_level,
        input  down_level
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output up,
        output down,
        output up_level,
        output down_level
    );
endinterface

// File: rtl/antirrebote_updown.sv
// rtl/antirrebote_updown.sv - two-channel button synchronizer/debouncer producing one-cycle up/down pulses
// Optional hold-to-repeat pulses are built only when ANTIRREBOTE_AUTOREPEAT_EN is defined.
module antirrebote_updown #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic                  clk,
    input  logic                  rst,
    antirrebote_updown_if.slave   bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SUELTO,
        VALIDANDO_PRESION,
        PRESIONADO,
        VALIDANDO_SUELTA
    } state_t;

    logic [1:0] btn_raw;
    logic [1:0] raw_pulse;
    logic [1:0] level;
    logic       up_q;
    logic       down_q;

    assign btn_raw = {bus.btn_down, bus.btn_up};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic          s1;
        logic          s2;
        logic          lvl;
        logic          press_done;
        logic          rep_fire;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= btn_raw[g];
                s2 <= s1;
            end
        end

        assign press_done = (state == VALIDANDO_PRESION) && s2 && (cnt == CNT_LAST);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= SUELTO;
                cnt   <= '0;
                lvl   <= 1'b0;
            end else begin
                case (state)
                    SUELTO: begin
                        if (s2) begin
                            state <= VALIDANDO_PRESION;
                            cnt   <= CW'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    VALIDANDO_PRESION: begin
                        if (!s2) begin
                            state <= SUELTO;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= PRESIONADO;
                            cnt   <= '0;
                            lvl   <= 1'b1;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PRESIONADO: begin
                        if (!s2) begin
                            state <= VALIDANDO_SUELTA;
                            cnt   <= CW'(1);
                        end
                    end
                    VALIDANDO_SUELTA: begin
                        if (s2) begin
                            state <= PRESIONADO;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state <= SUELTO;
                            cnt   <= '0;
                            lvl   <= 1'b0;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= SUELTO;
                        cnt   <= '0;
                    end
                endcase
            end
        end

`ifdef ANTIRREBOTE_AUTOREPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW   = $clog2(RMAX + 1);
        localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] rcnt;
        logic          rarmed;

        // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; only while still held.
        assign rep_fire = (state == PRESIONADO) && s2 &&
                          (rcnt == (rarmed ? PERIOD_LAST : DELAY_LAST));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt   <= '0;
                rarmed <= 1'b0;
            end else if ((state == PRESIONADO) && s2) begin
                if (rep_fire) begin
                    rcnt   <= '0;
                    rarmed <= 1'b1;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
            end else begin
                rcnt   <= '0;
                rarmed <= 1'b0;
            end
        end
`else
        assign rep_fire = 1'b0;
`endif

        assign raw_pulse[g] = press_done | rep_fire;
        assign level[g]     = lvl;
    end

    // Coincident pulses cancel so the counter never sees up and down together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= raw_pulse[0] & ~raw_pulse[1];
            down_q <= raw_pulse[1] & ~raw_pulse[0];
        end
    end

    assign bus.up         = up_q;
    assign bus.down       = down_q;
    assign bus.up_level   = level[0];
    assign bus.down_level = level[1];

endmodule

// File: tb/tb_antirrebote_updown.sv
// tb/tb_antirrebote_updown.sv - directed bench for antirrebote_updown with DEBOUNCE_CYCLES=4
module tb_antirrebote_updown;

    logic clk;
    logic rst;
    antirrebote_updown_if bus ();

    antirrebote_updown #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int up_at[$];
    int dn_at[$];
    int up_rise, up_fall, dn_rise, dn_fall, both_cnt;
    logic pu, pd;

    task automatic clear_rec();
        up_at.delete();
        dn_at.delete();
        up_rise  = -1;
        up_fall  = -1;
        dn_rise  = -1;
        dn_fall  = -1;
        both_cnt = 0;
        pu = bus.up_level;
        pd = bus.down_level;
    endtask

    // Edge index e counts from the first edge at which s1 samples the new stimulus.
    task automatic rec_edge(input int e);
        @(posedge clk);
        #1;
        if (bus.up)   up_at.push_back(e);
        if (bus.down) dn_at.push_back(e);
        if (bus.up && bus.down) both_cnt++;
        if (bus.up_level && !pu)   up_rise = e;
        if (!bus.up_level && pu)   up_fall = e;
        if (bus.down_level && !pd) dn_rise = e;
        if (!bus.down_level && pd) dn_fall = e;
        pu = bus.up_level;
        pd = bus.down_level;
    endtask

    task automatic hold(input logic bu, input logic bd, input int n);
        clear_rec();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.btn_up   = bu;
            bus.btn_down = bd;
            rec_edge(i);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.up !== 1'b0) begin failures++; $display("FAIL reset_up got=%b exp=0", bus.up); end
        checks++;
        if (bus.down !== 1'b0) begin failures++; $display("FAIL reset_down got=%b exp=0", bus.down); end
        checks++;
        if (bus.up_level !== 1'b0) begin failures++; $display("FAIL reset_up_level got=%b exp=0", bus.up_level); end
        checks++;
        if (bus.down_level !== 1'b0) begin failures++; $display("FAIL reset_down_level got=%b exp=0", bus.down_level); end
        @(negedge clk);
        rst = 1'b0;
        clear_rec();
        for (int i = 0; i < 12; i++) rec_edge(i);
        checks++;
        if (up_at.size() != 1 || up_at[0] != 5) begin
            failures++; $display("FAIL reset_release_pulse got=%p exp='{5}", up_at);
        end
        checks++;
        if (up_rise != 5) begin failures++; $display("FAIL reset_release_level got=%0d exp=5", up_rise); end
        hold(1'b0, 1'b0, 10);
    endtask

    task automatic test_clean_press();
        hold(1'b1, 1'b0, 20);
        checks++;
        if (up_at.size() != 1 || up_at[0] != 5) begin
            failures++; $display("FAIL clean_pulse got=%p exp='{5}", up_at);
        end
        checks++;
        if (up_rise != 5) begin failures++; $display("FAIL clean_level_rise got=%0d exp=5", up_rise); end
        checks++;
        if (dn_at.size() != 0) begin failures++; $display("FAIL clean_no_down got=%p exp=empty", dn_at); end
        hold(1'b0, 1'b0, 10);
        checks++;
        if (up_fall != 5) begin failures++; $display("FAIL clean_level_fall got=%0d exp=5", up_fall); end
        checks++;
        if (up_at.size() != 0) begin failures++; $display("FAIL clean_release_pulse got=%p exp=empty", up_at); end
    endtask

    task automatic test_bounce();
        logic pat [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        clear_rec();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.btn_down = pat[i];
            rec_edge(i);
        end
        checks++;
        if (dn_at.size() != 1 || dn_at[0] != 10) begin
            failures++; $display("FAIL bounce_pulse got=%p exp='{10}", dn_at);
        end
        checks++;
        if (dn_rise != 10) begin failures++; $display("FAIL bounce_level_rise got=%0d exp=10", dn_rise); end
        hold(1'b0, 1'b0, 10);
        checks++;
        if (dn_fall != 5) begin failures++; $display("FAIL bounce_level_fall got=%0d exp=5", dn_fall); end
    endtask

    task automatic test_glitch();
        clear_rec();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.btn_up = (i < 3);
            rec_edge(i);
        end
        checks++;
        if (up_at.size() != 0) begin failures++; $display("FAIL glitch_pulse got=%p exp=empty", up_at); end
        checks++;
        if (up_rise != -1 || bus.up_level !== 1'b0) begin
            failures++; $display("FAIL glitch_level rise=%0d level=%b exp=-1/0", up_rise, bus.up_level);
        end
    endtask

    task automatic test_min_press();
        clear_rec();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.btn_up = (i < 4);
            rec_edge(i);
        end
        checks++;
        if (up_at.size() != 1 || up_at[0] != 5) begin
            failures++; $display("FAIL min_press_pulse got=%p exp='{5}", up_at);
        end
        checks++;
        if (up_rise != 5 || up_fall != 9) begin
            failures++; $display("FAIL min_press_level rise=%0d fall=%0d exp=5/9", up_rise, up_fall);
        end
    endtask

    task automatic test_simultaneous();
        hold(1'b1, 1'b1, 12);
        checks++;
        if (up_at.size() != 0 || dn_at.size() != 0) begin
            failures++; $display("FAIL simul_pulses up=%p down=%p exp=empty", up_at, dn_at);
        end
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL simul_both got=%0d exp=0", both_cnt); end
        checks++;
        if (up_rise != 5 || dn_rise != 5) begin
            failures++; $display("FAIL simul_levels up_rise=%0d down_rise=%0d exp=5/5", up_rise, dn_rise);
        end
        hold(1'b0, 1'b0, 10);
    endtask

    task automatic test_reset_mid_press();
        hold(1'b1, 1'b0, 8);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.up_level !== 1'b0) begin
            failures++; $display("FAIL async_reset_level got=%b exp=0", bus.up_level);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_rec();
        for (int i = 0; i < 12; i++) rec_edge(i);
        checks++;
        if (up_at.size() != 1 || up_at[0] != 5) begin
            failures++; $display("FAIL reset_repress_pulse got=%p exp='{5}", up_at);
        end
        hold(1'b0, 1'b0, 10);
    endtask

    task automatic test_autorepeat();
        int exp_q[$];
        int exp_rel[$];
        logic ok;
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
        exp_q   = '{5, 13, 16, 19, 22, 25, 28};
        exp_rel = '{1};
`else
        exp_q   = '{5};
        exp_rel = '{};
`endif
        hold(1'b1, 1'b0, 30);
        ok = (up_at.size() == exp_q.size());
        for (int i = 0; i < up_at.size() && ok; i++) if (up_at[i] != exp_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL autorepeat_hold got=%p exp=%p", up_at, exp_q); end
        hold(1'b0, 1'b0, 10);
        ok = (up_at.size() == exp_rel.size());
        for (int i = 0; i < up_at.size() && ok; i++) if (up_at[i] != exp_rel[i]) ok = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL autorepeat_release got=%p exp=%p", up_at, exp_rel); end
        checks++;
        if (up_fall != 5) begin failures++; $display("FAIL autorepeat_level_fall got=%0d exp=5", up_fall); end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_min_press();
        test_simultaneous();
        test_reset_mid_press();
        test_autorepeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
